// File: rtl/fifo_write_arbiter_pkg.sv
// Shared arbiter state encoding and {id, data} FIFO word layout, also used by the
// read-side consumer of the stripe buffer.
package spraid_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_e;

   // Source ID occupies the MSBs of each FIFO word, payload the LSBs.
   function automatic int unsigned fifo_word_width(int unsigned id_width,
                                                   int unsigned data_width);
      return id_width + data_width;
   endfunction

   function automatic int unsigned fifo_id_lsb(int unsigned data_width);
      return data_width;
   endfunction

   function automatic int unsigned fifo_id_msb(int unsigned id_width, int unsigned data_width);
      return id_width + data_width - 1;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester-side handshake plus FIFO write-port bundle for the write arbiter.
interface fifo_write_arbiter_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned ID_WIDTH   = $clog2(NUM_REQ);
   localparam int unsigned FIFO_WIDTH = ID_WIDTH + DATA_WIDTH;

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_write_en;
   logic [FIFO_WIDTH-1:0]         fifo_din;

   modport master (
      output req_valid, req_data, req_last, fifo_full,
      input  req_ready, fifo_write_en, fifo_din
   );

   modport slave (
      input  req_valid, req_data, req_last, fifo_full,
      output req_ready, fifo_write_en, fifo_din
   );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning ptr, ptr+1, ...
// modulo NUM_REQ.
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] ptr,
   output logic [ID_WIDTH-1:0] idx,
   output logic                found
);

   localparam logic [ID_WIDTH:0] NUM = (ID_WIDTH+1)'(NUM_REQ);

   logic [ID_WIDTH:0]   sum;
   logic [ID_WIDTH-1:0] cand;

   always_comb begin
      idx   = '0;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         // ptr < NUM_REQ, so one conditional subtract performs the wrap.
         sum = {1'b0, ptr} + (ID_WIDTH+1)'(k);
         if (sum >= NUM) begin
            sum = sum - NUM;
         end
         cand = sum[ID_WIDTH-1:0];
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one sync_fifo write port between NUM_REQ requesters;
// each written word is tagged with its source ID in the MSBs.
module fifo_write_arbiter
   import spraid_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BURST_LEN  = 4,
   localparam int unsigned ID_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   fifo_write_arbiter_if.slave  bus,
   output logic [ID_WIDTH-1:0]  grant_id,
   output logic                 busy
);

   localparam int unsigned CNT_WIDTH = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned FIFO_WIDTH = fifo_word_width(ID_WIDTH, DATA_WIDTH);
   localparam int unsigned ID_LSB     = fifo_id_lsb(DATA_WIDTH);
   localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);
   localparam logic [ID_WIDTH-1:0]  LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

   arb_state_e           state;
   logic [ID_WIDTH-1:0]  rr_ptr;
   logic [CNT_WIDTH-1:0] beat_cnt;

   logic [ID_WIDTH-1:0]   pick_idx;
   logic                  pick_found;
   logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_valid;
   logic                  sel_last;
   logic                  in_burst;
   logic                  xfer;
   logic                  burst_end;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req   (bus.req_valid),
      .ptr   (rr_ptr),
      .idx   (pick_idx),
      .found (pick_found)
   );

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign data_arr[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   always_comb begin
      sel_valid = bus.req_valid[grant_id];
      sel_last  = bus.req_last[grant_id];
      sel_data  = data_arr[grant_id];
      // Reset gates everything combinationally so an in-flight word is never written.
      in_burst  = (state == ARB_BURST) && !reset;
      xfer      = in_burst && sel_valid && !bus.fifo_full;
      burst_end = in_burst &&
                  (!sel_valid || (xfer && (sel_last || (beat_cnt == LAST_BEAT))));
   end

   always_comb begin
      bus.req_ready     = '0;
      bus.fifo_write_en = xfer;
      bus.fifo_din      = '0;
      busy              = in_burst;
      if (in_burst && !bus.fifo_full) begin
         bus.req_ready = NUM_REQ'(1) << grant_id;
      end
      if (xfer) begin
         bus.fifo_din[FIFO_WIDTH-1:ID_LSB] = grant_id;
         bus.fifo_din[ID_LSB-1:0]          = sel_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ARB_IDLE;
         grant_id <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         unique case (state)
            ARB_IDLE: begin
               if (pick_found) begin
                  grant_id <= pick_idx;
                  state    <= ARB_BURST;
               end
            end
            ARB_BURST: begin
               if (burst_end) begin
                  state    <= ARB_IDLE;
                  beat_cnt <= '0;
                  rr_ptr   <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
               end else if (xfer) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(bus.req_ready));
   a_no_overflow:  assert property (@(posedge clk) !(bus.fifo_write_en && bus.fifo_full));
   a_beat_bound:   assert property (@(posedge clk) disable iff (reset) beat_cnt <= LAST_BEAT);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized bench: two arbiter configurations (4 req / burst 4, 3 req / burst 1) driven
// by holding requesters and checked every cycle against a behavioural model.
module tb_fifo_write_arbiter;

   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   fifo_write_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(DW)) bus_a ();
   fifo_write_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(DW)) bus_b ();

   logic [1:0] gid_a, gid_b;
   logic       busy_a, busy_b;

   fifo_write_arbiter #(
      .NUM_REQ    (4),
      .DATA_WIDTH (DW),
      .BURST_LEN  (4)
   ) dut_a (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus_a),
      .grant_id (gid_a),
      .busy     (busy_a)
   );

   fifo_write_arbiter #(
      .NUM_REQ    (3),
      .DATA_WIDTH (DW),
      .BURST_LEN  (1)
   ) dut_b (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus_b),
      .grant_id (gid_b),
      .busy     (busy_b)
   );

   int n_checks = 0;
   int n_bad    = 0;

   // Requester k/i holds a word (data, last flag) until the model says it was taken.
   bit          pres  [2][4];
   logic [31:0] pdata [2][4];
   bit          plast [2][4];
   bit          full  [2];

   // Model: which requester owns the port, who is favoured next, words taken so far.
   bit          owned   [2];
   int unsigned owner   [2];
   int unsigned favour  [2];
   int unsigned taken   [2];

   function automatic int unsigned nreq(input int k);
      return (k == 0) ? 4 : 3;
   endfunction

   function automatic int unsigned blen(input int k);
      return (k == 0) ? 4 : 1;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
      end
   endtask

   task automatic check_cfg(input int k, input logic [3:0] rdy, input logic we,
                            input logic [33:0] din, input logic [1:0] gid, input logic bsy);
      logic [3:0]  e_rdy;
      logic        e_we;
      logic [33:0] e_din;
      logic [1:0]  g;
      string       pfx;
      pfx   = (k == 0) ? "a." : "b.";
      g     = 2'(owner[k]);
      e_rdy = '0;
      e_we  = 1'b0;
      e_din = '0;
      if (!reset && owned[k] && !full[k]) begin
         e_rdy[owner[k]] = 1'b1;
         e_we            = pres[k][owner[k]];
      end
      if (e_we) e_din = {g, pdata[k][owner[k]]};
      check_eq({pfx, "req_ready"}, 64'(rdy), 64'(e_rdy));
      check_eq({pfx, "fifo_write_en"}, 64'(we), 64'(e_we));
      check_eq({pfx, "fifo_din"}, 64'(din), 64'(e_din));
      check_eq({pfx, "grant_id"}, 64'(gid), 64'(g));
      check_eq({pfx, "busy"}, 64'(bsy), 64'(!reset && owned[k]));
   endtask

   task automatic model_step(input int k);
      int unsigned n, cand, g;
      bit          found, done;
      n = nreq(k);
      if (reset) begin
         owned[k]  = 1'b0;
         owner[k]  = 0;
         favour[k] = 0;
         taken[k]  = 0;
      end else if (!owned[k]) begin
         found = 1'b0;
         for (int unsigned s = 0; s < n; s++) begin
            cand = (favour[k] + s) % n;
            if (!found && pres[k][cand]) begin
               found    = 1'b1;
               owned[k] = 1'b1;
               owner[k] = cand;
            end
         end
      end else begin
         g    = owner[k];
         done = 1'b0;
         if (!pres[k][g]) begin
            done = 1'b1;
         end else if (!full[k]) begin
            pres[k][g] = 1'b0;
            taken[k]++;
            done = plast[k][g] || (taken[k] == blen(k));
         end
         if (done) begin
            owned[k]  = 1'b0;
            taken[k]  = 0;
            favour[k] = (g + 1) % n;
         end
      end
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         bus_a.req_valid[i]            = pres[0][i];
         bus_a.req_last[i]             = plast[0][i];
         bus_a.req_data[i*DW +: DW]    = pdata[0][i];
      end
      for (int i = 0; i < 3; i++) begin
         bus_b.req_valid[i]            = pres[1][i];
         bus_b.req_last[i]             = plast[1][i];
         bus_b.req_data[i*DW +: DW]    = pdata[1][i];
      end
      bus_a.fifo_full = full[0];
      bus_b.fifo_full = full[1];
   endtask

   task automatic run_cycle(input int p_valid, input int p_last, input int p_full,
                            input int p_reset);
      @(negedge clk);
      reset = (($urandom % 100) < p_reset);
      for (int k = 0; k < 2; k++) begin
         full[k] = (($urandom % 100) < p_full);
         for (int i = 0; i < 4; i++) begin
            if (!pres[k][i] && (($urandom % 100) < p_valid)) begin
               pres[k][i]  = 1'b1;
               pdata[k][i] = $urandom;
               plast[k][i] = (($urandom % 100) < p_last);
            end
         end
      end
      drive();
      #1;
      check_cfg(0, bus_a.req_ready, bus_a.fifo_write_en, bus_a.fifo_din, gid_a, busy_a);
      check_cfg(1, {1'b0, bus_b.req_ready}, bus_b.fifo_write_en, bus_b.fifo_din, gid_b,
                busy_b);
      @(posedge clk);
      model_step(0);
      model_step(1);
   endtask

   typedef struct {
      int p_valid;
      int p_last;
      int p_full;
      int p_reset;
      int cycles;
   } phase_t;

   phase_t phases [5];

   initial begin
      phases[0] = '{0, 0, 0, 100, 3};     // held reset: all outputs quiet
      phases[1] = '{100, 0, 0, 0, 60};    // everyone streaming, full bursts
      phases[2] = '{60, 25, 0, 0, 200};   // early last / dropped valid
      phases[3] = '{70, 20, 35, 0, 300};  // heavy backpressure
      phases[4] = '{55, 25, 25, 3, 400};  // random mid-burst resets

      for (int k = 0; k < 2; k++) begin
         full[k]   = 1'b0;
         owned[k]  = 1'b0;
         owner[k]  = 0;
         favour[k] = 0;
         taken[k]  = 0;
         for (int i = 0; i < 4; i++) begin
            pres[k][i]  = 1'b0;
            pdata[k][i] = '0;
            plast[k][i] = 1'b0;
         end
      end
      reset = 1'b1;
      drive();
      @(posedge clk);

      for (int p = 0; p < 5; p++) begin
         for (int c = 0; c < phases[p].cycles; c++) begin
            run_cycle(phases[p].p_valid, phases[p].p_last, phases[p].p_full,
                      phases[p].p_reset);
         end
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
